// File: rtl/ula_pkg.sv
// ula_pkg: shared constants and types for the ULA result-bus sequencer.
//   - opcode constants (unit index on the shared result bus)
//   - default datapath width and number of bus-driving units
//   - FSM state encoding used by ula_bus_reader
package ula_pkg;

    localparam int ULA_WIDTH     = 8;
    localparam int ULA_NUM_UNITS = 5;
    localparam int ULA_OP_W      = 3;
    localparam int ULA_CNT_W     = 3;

    localparam logic [ULA_OP_W-1:0] OP_AND = 3'd0;
    localparam logic [ULA_OP_W-1:0] OP_OR  = 3'd1;
    localparam logic [ULA_OP_W-1:0] OP_XOR = 3'd2;
    localparam logic [ULA_OP_W-1:0] OP_ADD = 3'd3;
    localparam logic [ULA_OP_W-1:0] OP_SUB = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage : ula_pkg

// File: rtl/ula_en_decoder.sv
// ula_en_decoder: combinational opcode to one-hot bus-enable decoder.
// Ports:
//   op      - unit select
//   enable  - gate; en is all-zero when low
//   en      - one-hot (or zero) enable for the tri-state drivers
//   invalid - op does not name an existing unit
module ula_en_decoder
    import ula_pkg::*;
#(
    parameter int NUM_UNITS = ULA_NUM_UNITS
) (
    input  logic [ULA_OP_W-1:0]  op,
    input  logic                 enable,
    output logic [NUM_UNITS-1:0] en,
    output logic                 invalid
);

    // Range check and one-hot decode; an out-of-range op never enables a unit.
    always_comb begin
        en      = {NUM_UNITS{1'b0}};
        invalid = ({1'b0, op} >= 4'(NUM_UNITS));
        for (int i = 0; i < NUM_UNITS; i++) begin
            en[i] = enable & ~invalid & (op == 3'(i));
        end
    end

endmodule : ula_en_decoder

// File: rtl/ula_bus_reader.sv
// ula_bus_reader: accepts one operation request, enables exactly one unit
// onto the shared WIDTH+1 bit result bus for SETTLE cycles, samples the bus
// and holds the result until the consumer takes it.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   req_valid/req_ready          - request handshake
//   req_op, req_a, req_b         - unit select and operands
//   opnd_a, opnd_b               - latched operands fanned out to the units
//   en                           - one-hot unit bus enables (sole driver)
//   bus_in                       - shared result bus, MSB is carry
//   res_valid/res_ready          - result handshake
//   res_data, res_carry,
//   res_zero, res_err            - captured result and flags
module ula_bus_reader
    import ula_pkg::*;
#(
    parameter int WIDTH     = ULA_WIDTH,
    parameter int NUM_UNITS = ULA_NUM_UNITS,
    parameter int SETTLE    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ULA_OP_W-1:0]  req_op,
    input  logic [WIDTH-1:0]     req_a,
    input  logic [WIDTH-1:0]     req_b,
    output logic [WIDTH-1:0]     opnd_a,
    output logic [WIDTH-1:0]     opnd_b,
    output logic [NUM_UNITS-1:0] en,
    input  logic [WIDTH:0]       bus_in,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WIDTH-1:0]     res_data,
    output logic                 res_carry,
    output logic                 res_zero,
    output logic                 res_err
);

    state_e                 state_r;
    state_e                 state_next_s;
    logic [ULA_CNT_W-1:0]   cnt_r;
    logic [ULA_OP_W-1:0]    op_r;
    logic [ULA_OP_W-1:0]    op_next_s;
    logic                   accept_s;
    logic                   capture_s;
    logic                   drive_next_s;
    logic [NUM_UNITS-1:0]   en_next_s;
    logic                   invalid_s;

    // Next-state logic: accept in IDLE, sample when the settle count expires,
    // release on res_ready. No DONE->IDLE->DRIVE bypass in one cycle.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_DRIVE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (cnt_r == {ULA_CNT_W{1'b0}}) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRIVE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // The op seen by the decoder is the one that will be latched, so the
    // registered en lines up with the first DRIVE cycle.
    always_comb begin
        if (accept_s) begin
            op_next_s = req_op;
        end else begin
            op_next_s = op_r;
        end
        drive_next_s = (state_next_s == ST_DRIVE);
    end

    ula_en_decoder #(
        .NUM_UNITS (NUM_UNITS)
    ) u_en_decoder (
        .op      (op_next_s),
        .enable  (drive_next_s),
        .en      (en_next_s),
        .invalid (invalid_s)
    );

    // State, counter, operand latch, registered handshake/enable outputs and
    // result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {ULA_CNT_W{1'b0}};
            op_r      <= {ULA_OP_W{1'b0}};
            opnd_a    <= {WIDTH{1'b0}};
            opnd_b    <= {WIDTH{1'b0}};
            en        <= {NUM_UNITS{1'b0}};
            req_ready <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= {WIDTH{1'b0}};
            res_carry <= 1'b0;
            res_zero  <= 1'b0;
            res_err   <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            en        <= en_next_s;
            req_ready <= (state_next_s == ST_IDLE);
            res_valid <= (state_next_s == ST_DONE);
            if (accept_s) begin
                op_r   <= req_op;
                opnd_a <= req_a;
                opnd_b <= req_b;
                cnt_r  <= 3'(SETTLE - 1);
            end else if (state_r == ST_DRIVE && cnt_r != {ULA_CNT_W{1'b0}}) begin
                cnt_r <= cnt_r - 3'd1;
            end
            if (capture_s) begin
                res_err <= invalid_s;
                // No unit was enabled for an invalid op, so the bus is
                // floating and must not be sampled.
                if (invalid_s) begin
                    res_data  <= {WIDTH{1'b0}};
                    res_carry <= 1'b0;
                    res_zero  <= 1'b1;
                end else begin
                    res_data  <= bus_in[WIDTH-1:0];
                    res_carry <= bus_in[WIDTH];
                    res_zero  <= (bus_in[WIDTH-1:0] == {WIDTH{1'b0}});
                end
            end
        end
    end

endmodule : ula_bus_reader

// File: tb/tb_ula_bus_reader.sv
// tb_ula_bus_reader: two DUT instances (SETTLE=1 and SETTLE=3) share the
// request stimulus; sel chooses which one sees req_valid and is observed.
// Each DUT's bus is driven by a model of the five function units.
module tb_ula_bus_reader;
    import ula_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, res_ready;
    logic [2:0] req_op;
    logic [7:0] req_a, req_b;
    int         sel;

    logic       rr1, rv1, rc1, rz1, re1, rr3, rv3, rc3, rz3, re3;
    logic [7:0] oa1, ob1, rd1, oa3, ob3, rd3;
    logic [4:0] en1, en3;
    logic [8:0] bus1, bus3;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ula_bus_reader #(.WIDTH(8), .NUM_UNITS(5), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel == 0), .req_ready(rr1),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .opnd_a(oa1), .opnd_b(ob1),
        .en(en1), .bus_in(bus1), .res_valid(rv1), .res_ready(res_ready),
        .res_data(rd1), .res_carry(rc1), .res_zero(rz1), .res_err(re1));

    ula_bus_reader #(.WIDTH(8), .NUM_UNITS(5), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel == 1), .req_ready(rr3),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .opnd_a(oa3), .opnd_b(ob3),
        .en(en3), .bus_in(bus3), .res_valid(rv3), .res_ready(res_ready),
        .res_data(rd3), .res_carry(rc3), .res_zero(rz3), .res_err(re3));

    // Function-unit behaviour: 9-bit result, MSB is carry (borrow for SUB).
    function automatic logic [8:0] unit_out(input int op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            0:       return {1'b0, a & b};
            1:       return {1'b0, a | b};
            2:       return {1'b0, a ^ b};
            3:       return {1'b0, a} + {1'b0, b};
            4:       return {1'b0, a} - {1'b0, b};
            default: return 9'h000;
        endcase
    endfunction

    // Bus: the enabled unit's value, otherwise a recognisable junk pattern.
    function automatic logic [8:0] bus_model(input logic [4:0] e, input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 5; i++) begin
            if (e == 5'(1 << i)) return unit_out(i, a, b);
        end
        return 9'h1A5;
    endfunction

    assign bus1 = bus_model(en1, oa1, ob1);
    assign bus3 = bus_model(en3, oa3, ob3);

    // Reference: {err, zero, carry, data} from the request alone.
    function automatic logic [10:0] ref_res(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] v;
        if (op >= 3'd5) return {1'b1, 1'b1, 1'b0, 8'h00};
        v = unit_out(int'(op), a, b);
        return {1'b0, v[7:0] == 8'h00, v[8], v[7:0]};
    endfunction

    wire        o_rr  = (sel == 1) ? rr3 : rr1;
    wire        o_rv  = (sel == 1) ? rv3 : rv1;
    wire [4:0]  o_en  = (sel == 1) ? en3 : en1;
    wire [10:0] o_res = (sel == 1) ? {re3, rz3, rc3, rd3} : {re1, rz1, rc1, rd1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Bus-contention invariant on both instances every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            check("onehot_en1", 32'($onehot0(en1)), 32'd1);
            check("onehot_en3", 32'($onehot0(en3)), 32'd1);
        end
    end

    // One transaction on the selected DUT; hold = cycles res_ready stays low
    // after res_valid, with junk toggled on req_valid/req_a meanwhile.
    task automatic run_txn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int hold);
        int settle;
        int k;
        int en_cnt;
        logic [4:0]  exp_en;
        logic [10:0] exp_res;
        logic [10:0] held;
        settle  = (sel == 1) ? 3 : 1;
        exp_en  = (op < 3'd5) ? 5'(1 << op) : 5'd0;
        exp_res = ref_res(op, a, b);
        k = 0;
        while (!o_rr && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ready_before_req", 32'(o_rr), 32'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; res_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check("ready_low_after_accept", 32'(o_rr), 32'd0);
        k = 1;
        en_cnt = 0;
        while (!o_rv && k < 20) begin
            check("en_value", 32'(o_en), 32'(exp_en));
            if (o_en != 5'd0) en_cnt++;
            req_a = 8'($urandom);
            @(negedge clk);
            k++;
        end
        check("res_latency", 32'(k), 32'(settle + 1));
        check("en_cycles", 32'(en_cnt), (exp_en != 5'd0) ? 32'(settle) : 32'd0);
        check("en_off_at_valid", 32'(o_en), 32'd0);
        check("result", 32'(o_res), 32'(exp_res));
        held = o_res;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'($urandom);
            req_a = 8'($urandom);
            @(negedge clk);
            if (i == hold - 1 || hold < 4) begin
                check("hold_stable", 32'(o_res), 32'(held));
                check("hold_ready_low", 32'(o_rr), 32'd0);
                check("hold_valid", 32'(o_rv), 32'd1);
            end
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("ready_after_take", 32'(o_rr), 32'd1);
        check("valid_after_take", 32'(o_rv), 32'd0);
        check("no_second_txn_en", 32'(o_en), 32'd0);
    endtask

    initial begin
        logic [10:0] exp_q[$];
        int acc_cyc[$];
        int k;
        int got;
        rst = 1'b1; req_valid = 1'b0; res_ready = 1'b0; req_op = 3'd0;
        req_a = 8'h00; req_b = 8'h00; sel = 1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ready1", 32'(rr1), 32'd1);
        check("rst_state3", 32'({rr3, rv3, en3, re3, rz3, rc3, rd3, oa3, ob3}), 32'({1'b1, 1'b0, 5'd0, 27'd0}));

        // Reset mid-DRIVE, SETTLE=3, OP_ADD.
        req_valid = 1'b1; req_op = OP_ADD; req_a = 8'h12; req_b = 8'h34;
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_en", 32'(en3), 32'h8);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_mid_en", 32'(en3), 32'd0);
        check("rst_mid_valid", 32'(rv3), 32'd0);
        check("rst_mid_ready", 32'(rr3), 32'd1);
        check("rst_mid_res", 32'({re3, rz3, rc3, rd3}), 32'd0);

        // Directed cases.
        sel = 0; run_txn(OP_AND, 8'hF0, 8'h3C, 0);
        sel = 1; run_txn(OP_ADD, 8'hFF, 8'h01, 0);
        sel = 0; run_txn(3'd6, 8'h55, 8'hAA, 0);
        sel = 1; run_txn(3'd7, 8'h01, 8'h02, 1);
        sel = 0; run_txn(OP_SUB, 8'h10, 8'h20, 10);
        sel = 1; run_txn(OP_XOR, 8'h5A, 8'h5A, 10);

        // Randomized transactions.
        for (int i = 0; i < 16; i++) begin
            sel = int'($urandom_range(0, 1));
            run_txn(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        // Back-to-back on SETTLE=1 with req_valid and res_ready held high.
        sel = 0;
        res_ready = 1'b1;
        req_valid = 1'b1;
        req_op = 3'($urandom_range(0, 4)); req_a = 8'($urandom); req_b = 8'($urandom);
        got = 0;
        k = 0;
        while ((got < 4) && k < 40) begin
            if (rv1) begin
                if (exp_q.size() > 0) begin
                    check("b2b_result", 32'({re1, rz1, rc1, rd1}), 32'(exp_q.pop_front()));
                end else begin
                    check("b2b_unexpected", 32'd1, 32'd0);
                end
                got++;
            end
            if (rr1 && req_valid) begin
                exp_q.push_back(ref_res(req_op, req_a, req_b));
                acc_cyc.push_back(cyc);
                @(negedge clk);
                k++;
                if (acc_cyc.size() >= 4) req_valid = 1'b0;
                req_op = 3'($urandom_range(0, 7)); req_a = 8'($urandom); req_b = 8'($urandom);
            end else begin
                @(negedge clk);
                k++;
            end
        end
        req_valid = 1'b0;
        res_ready = 1'b0;
        check("b2b_count", 32'(got), 32'd4);
        check("b2b_accepts", 32'(acc_cyc.size()), 32'd4);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            check("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
        end
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_ula_bus_reader
